pixel_feeder: RTL and testbench
===============================

# pixel_feeder

Synthesizable image source for the sliding-window path. A host loads one IMG_W x IMG_H greyscale frame into an internal byte buffer. On a `go` pulse the block streams the frame out in raster order. It drives `start`, pixel data, and row and line markers into the window generator's `start`/`din` inputs, replacing the file-driven stimulus with a hardware-resident frame. It honours downstream back-pressure and reports frame completion.

## Interface
- `IMG_W`, 28, pixels per row
- `IMG_H`, 28, rows per frame
- `DW`, 8, pixel width
- `AW`, 10, buffer address width; must satisfy 2^AW >= IMG_W*IMG_H
- `clk`  in  1  rising-edge clock
- `rstn`  in  1  reset, asynchronous, active-low
- `wr_en`  in  1  buffer write strobe
- `wr_addr`  in  AW  linear pixel index, row*IMG_W+col
- `wr_data`  in  DW  pixel to store
- `go`  in  1  single-cycle request to stream one frame
- `stall`  in  1  downstream hold; freezes the stream
- `busy`  out  1  high in any state other than IDLE
- `start`  out  1  window enable; high from the first issued read through the last valid pixel
- `dout`  out  DW  pixel
- `dout_valid`  out  1  `dout` carries a new pixel this cycle
- `sol`  out  1  with `dout_valid`: first pixel of a row
- `eol`  out  1  with `dout_valid`: last pixel of a row
- `frame_done`  out  1  one-cycle pulse after the last pixel

## Operation
- Buffer: IMG_W*IMG_H x DW synchronous RAM.
  - One write port and one read port; read latency 1 cycle.
  - Contents are not cleared by reset.
- FSM states:
  - IDLE: writes accepted. `go` moves to STREAM.
  - STREAM: row and column counters advance one pixel per non-stalled cycle. Issuing the final address moves to DRAIN.
  - DRAIN: waits for the final pixel to leave the output stage, then moves to DONE.
  - DONE: asserts `frame_done` for one cycle, then returns to IDLE.
- Writes:
  - Accepted only in IDLE; ignored in every other state.
  - `wr_addr >= IMG_W*IMG_H` is ignored.
- `go` outside IDLE is ignored and not queued.
- `wr_en` and `go` asserted together in IDLE: the write completes, and the stream reads the updated content.
- Counters: column counter runs 0..IMG_W-1 and wraps. The row counter increments on each column wrap. Read address = row*IMG_W+col, kept as a running linear counter with no multiplier.
- `sol`/`eol` are derived from the column of the pixel being presented and are gated by `dout_valid`.
- `stall` high:
  - The address counter, RAM read enable and output stage all hold.
  - `dout_valid` = 0 for that cycle; `dout` holds its value.
  - No pixel is lost or duplicated.
- Reset at any time, including mid-frame:
  - State returns to IDLE and counters clear.
  - All outputs go to 0: `busy`, `start`, `dout`, `dout_valid`, `sol`, `eol`, `frame_done`.

## Timing
- `go` sampled high at edge N, no stall:
  - `busy` and `start` rise at N+1, when address 0 is issued.
  - First `dout_valid` at N+2; pixels are consecutive.
  - Last pixel valid at N+1+IMG_W*IMG_H; `start` falls after it.
  - `frame_done` pulses at N+2+IMG_W*IMG_H; `busy` falls one cycle later.
- Each stall cycle extends every later event by exactly one cycle.
- A new `go` is accepted on the cycle after `busy` falls.

## Configuration
- `FEEDER_PAD_EN` defined:
  - The output frame is (IMG_W+4) x (IMG_H+4), a 2-pixel zero border sized for the 5-tap window.
  - Border pixels have `dout` = 0 and do not read the RAM.
  - `sol`/`eol` mark padded row edges; the frame length is (IMG_W+4)*(IMG_H+4).
- `FEEDER_PAD_EN` undefined: the output frame is exactly IMG_W x IMG_H with no border logic.

## Test plan
- Reset check: assert `rstn`=0 with random inputs -> all outputs 0; a `go` issued after reset release with an empty load still streams 784 pixels.
- Ramp frame: load pixel[i] = i mod 256, `go` at cycle N -> 784 consecutive valid pixels from N+2.
  - Expected values are 0,1,...,255,0,...
  - `sol` at indices 0,28,56,...; `eol` at 27,55,...
  - `frame_done` at N+786.
- Back-pressure: same frame with `stall` high 3 cycles on pixel 100 and on every 50th cycle -> data sequence identical, with the end shifted by the total stall count.
- Protection:
  - `wr_en` with `wr_addr`=5, `wr_data`=0xFF during STREAM -> no effect.
  - `wr_addr`=900 in IDLE -> no effect.
  - `go` during STREAM -> no second frame.
- Mid-frame reset: pulse `rstn` low at pixel 400 -> outputs 0 at once; a subsequent `go` streams the full frame with buffer contents intact.
- With `FEEDER_PAD_EN`:
  - Ramp frame -> 1024 pixels, with rows 0,1,30,31 and columns 0,1,30,31 zero.
  - Pixel (2,2) = 0x00 and pixel (2,3) = 0x01.

Source files
------------

// File: rtl/pixel_feeder.sv
// pixel_feeder: on-chip frame buffer that replays a loaded greyscale image in raster order
// with back-pressure. Define FEEDER_PAD_EN to wrap the frame in a 2-pixel zero border.
module pixel_feeder #(
   parameter int IMG_W = 28,
   parameter int IMG_H = 28,
   parameter int DW    = 8,
   parameter int AW    = 10
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   input  logic          go,
   input  logic          stall,
   output logic          busy,
   output logic          start,
   output logic [DW-1:0] dout,
   output logic          dout_valid,
   output logic          sol,
   output logic          eol,
   output logic          frame_done
);

`ifdef FEEDER_PAD_EN
   localparam int PAD = 2;
`else
   localparam int PAD = 0;
`endif
   localparam int NPIX = IMG_W * IMG_H;
   localparam int OW   = IMG_W + 2 * PAD;
   localparam int OH   = IMG_H + 2 * PAD;
   localparam int CW   = $clog2(OW + 1);
   localparam int RW   = $clog2(OH + 1);
   localparam logic [CW-1:0] COL_LAST = CW'(OW - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(OH - 1);
   localparam logic [AW:0]   NPIX_W   = (AW + 1)'(NPIX);

   typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

   state_t        state, state_nxt;
   logic [DW-1:0] mem [NPIX];
   logic [CW-1:0] col, pix_col;
   logic [RW-1:0] row;
   logic [AW-1:0] addr;
   logic [DW-1:0] dout_q;
   logic          pix_vld;
   logic          wr_ok, issue, last_issue, interior;

   // Loads are only taken while idle so a frame never sees a torn image.
   assign wr_ok = rstn && wr_en && (state == IDLE) && ({1'b0, wr_addr} < NPIX_W);

   always_ff @(posedge clk)
      if (wr_ok) mem[wr_addr] <= wr_data;

   assign issue      = (state == STREAM) && !stall;
   assign last_issue = issue && (col == COL_LAST) && (row == ROW_LAST);

`ifdef FEEDER_PAD_EN
   assign interior = (col >= CW'(PAD)) && (col < CW'(PAD + IMG_W)) &&
                     (row >= RW'(PAD)) && (row < RW'(PAD + IMG_H));
`else
   assign interior = 1'b1;
`endif

   always_ff @(posedge clk or negedge rstn)
      if (!rstn) state <= IDLE;
      else       state <= state_nxt;

   always_comb begin
      state_nxt  = state;
      busy       = (state != IDLE);
      start      = (state == STREAM) || (state == DRAIN);
      frame_done = (state == DONE);
      case (state)
         IDLE:    if (go) state_nxt = STREAM;
         STREAM:  if (last_issue) state_nxt = DRAIN;
         DRAIN:   if (!stall) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Linear address runs alongside row/col so no multiplier is needed.
   always_ff @(posedge clk or negedge rstn)
      if (!rstn) begin
         col  <= '0;
         row  <= '0;
         addr <= '0;
      end else if (state == IDLE) begin
         col  <= '0;
         row  <= '0;
         addr <= '0;
      end else if (issue) begin
         if (col == COL_LAST) begin
            col <= '0;
            row <= row + 1'b1;
         end else begin
            col <= col + 1'b1;
         end
         if (interior) addr <= addr + 1'b1;
      end

   // RAM read register doubles as the output stage; stall freezes it in place.
   always_ff @(posedge clk or negedge rstn)
      if (!rstn) begin
         dout_q  <= '0;
         pix_vld <= 1'b0;
         pix_col <= '0;
      end else if (!stall) begin
         pix_vld <= issue;
         if (issue) begin
            pix_col <= col;
            dout_q  <= interior ? mem[addr] : '0;
         end
      end

   assign dout       = dout_q;
   assign dout_valid = pix_vld && !stall;
   assign sol        = dout_valid && (pix_col == '0);
   assign eol        = dout_valid && (pix_col == COL_LAST);

endmodule

// File: tb/tb_pixel_feeder.sv
// Bench for pixel_feeder: a timeline model (effective frame time advanced on non-stalled
// cycles) plus an image array predicts every output each cycle; literal checks pin the model.
module tb_pixel_feeder;
   localparam int IMG_W = 28;
   localparam int IMG_H = 28;
   localparam int DW    = 8;
   localparam int AW    = 10;
   localparam int NPIX  = IMG_W * IMG_H;
`ifdef FEEDER_PAD_EN
   localparam int PAD = 2;
`else
   localparam int PAD = 0;
`endif
   localparam int OW   = IMG_W + 2 * PAD;
   localparam int OH   = IMG_H + 2 * PAD;
   localparam int NOUT = OW * OH;

   logic          clk = 0, rstn = 0, wr_en = 0, go = 0, stall = 0;
   logic [AW-1:0] wr_addr = '0;
   logic [DW-1:0] wr_data = '0;
   logic          busy, start, dout_valid, sol, eol, frame_done;
   logic [DW-1:0] dout;

   pixel_feeder #(.IMG_W(IMG_W), .IMG_H(IMG_H), .DW(DW), .AW(AW)) dut (
      .clk(clk), .rstn(rstn), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .go(go), .stall(stall), .busy(busy), .start(start), .dout(dout),
      .dout_valid(dout_valid), .sol(sol), .eol(eol), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // model state
   logic [DW-1:0] img [NPIX];
   bit            known [NPIX];
   bit            m_active = 0;
   int            e = 0;
   int            errors = 0, checks = 0;
   logic [DW-1:0] got [$];
   int            go_cyc = -1, first_cyc = -1, done_cyc = -1, nsol = 0, neol = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // expected pixel at output index p from the image model; -1 when never written
   function automatic int exp_pix(input int p);
      int r, c, idx;
      r = p / OW;
      c = p % OW;
      if (r < PAD || r >= PAD + IMG_H || c < PAD || c >= PAD + IMG_W) return 0;
      idx = (r - PAD) * IMG_W + (c - PAD);
      return known[idx] ? int'(img[idx]) : -1;
   endfunction

   // ramp image: pixel i = i mod 256, border zero
   function automatic int ramp_mismatches();
      int r, c, ex, n;
      n = 0;
      if (got.size() != NOUT) return NOUT;
      for (int p = 0; p < NOUT; p++) begin
         r = p / OW;
         c = p % OW;
         if (r < PAD || r >= PAD + IMG_H || c < PAD || c >= PAD + IMG_W) ex = 0;
         else ex = ((r - PAD) * IMG_W + (c - PAD)) % 256;
         if (int'(got[p]) != ex) n++;
      end
      return n;
   endfunction

   always @(negedge clk) begin
      int  p, ev;
      bit  in_win, exp_vld;
      if (!rstn) begin
         check("rst_busy", busy, 0);
         check("rst_start", start, 0);
         check("rst_dout", dout, 0);
         check("rst_valid", dout_valid, 0);
         check("rst_sol", sol, 0);
         check("rst_eol", eol, 0);
         check("rst_done", frame_done, 0);
         m_active = 0;
         e = 0;
      end else begin
         in_win  = m_active && e >= 2 && e <= NOUT + 1;
         exp_vld = in_win && !stall;
         p       = e - 2;
         check("busy", busy, m_active);
         check("start", start, m_active && e <= NOUT + 1);
         check("frame_done", frame_done, m_active && e == NOUT + 2);
         check("dout_valid", dout_valid, exp_vld);
         check("sol", sol, exp_vld && (p % OW == 0));
         check("eol", eol, exp_vld && (p % OW == OW - 1));
         if (in_win) begin
            ev = exp_pix(p);
            if (ev >= 0) check("dout", dout, ev);
         end
         if (dout_valid) begin
            if (got.size() == 0) first_cyc = cyc;
            got.push_back(dout);
            if (sol) nsol++;
            if (eol) neol++;
         end
         if (frame_done) done_cyc = cyc;
         // advance model with the inputs the next edge will sample
         if (m_active) begin
            if (!(stall && e <= NOUT + 1)) e++;
            if (e > NOUT + 2) m_active = 0;
         end else begin
            if (wr_en && wr_addr < NPIX) begin
               img[wr_addr]   = wr_data;
               known[wr_addr] = 1;
            end
            if (go) begin
               m_active  = 1;
               e         = 1;
               go_cyc    = cyc;
               first_cyc = -1;
               done_cyc  = -1;
               nsol      = 0;
               neol      = 0;
               got.delete();
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      wr_en = 0;
      go    = 0;
      stall = 0;
   endtask

   task automatic load_ramp();
      for (int i = 0; i < NPIX; i++) begin
         wr_en   = 1;
         wr_addr = AW'(i);
         wr_data = DW'(i % 256);
         tick();
      end
      wr_en = 0;
   endtask

   // mode 0: no stall, 1: stall every 50th cycle + 3 on pixel 100, 2: random stall,
   // 3: no stall, but a write to address 5 and a second go mid-frame
   task automatic run_frame(input int mode, input bit noise, input int rst_at, output int nst);
      int s_left;
      bit s100, fin;
      s_left = 0;
      s100   = 0;
      fin    = 0;
      nst    = 0;
      go = 1;
      tick();
      go = 0;
      for (int k = 1; k <= 4 * NOUT; k++) begin
         if (!m_active) begin
            fin = 1;
            break;
         end
         idle_inputs();
         case (mode)
            1: begin
               if (got.size() == 100 && !s100) begin
                  s_left = 3;
                  s100   = 1;
               end
               stall = (k % 50 == 0) || (s_left > 0);
               if (s_left > 0) s_left--;
               if (k > NOUT) stall = 0;
            end
            2: stall = ($urandom_range(0, 3) == 0);
            3: begin
               if (k == 50) begin
                  wr_en   = 1;
                  wr_addr = AW'(5);
                  wr_data = 8'hFF;
               end
               if (k == 60) go = 1;
            end
            default: stall = 0;
         endcase
         if (stall) nst++;
         if (noise) begin
            wr_en   = ($urandom_range(0, 7) == 0);
            wr_addr = AW'($urandom_range(0, 1023));
            wr_data = DW'($urandom);
            go      = ($urandom_range(0, 15) == 0);
         end
         if (rst_at >= 0 && got.size() >= rst_at) begin
            idle_inputs();
            rstn = 0;
            tick();
            tick();
            rstn = 1;
            fin  = 1;
            break;
         end
         tick();
      end
      idle_inputs();
      check("frame_finished", fin, 1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
      $fatal(1);
   end

   initial begin
      int nst;
      rstn = 0;
      repeat (4) begin
         wr_en   = $urandom_range(0, 1);
         go      = $urandom_range(0, 1);
         stall   = $urandom_range(0, 1);
         wr_addr = AW'($urandom_range(0, 1023));
         wr_data = DW'($urandom);
         tick();
      end
      idle_inputs();
      rstn = 1;
      tick();
      tick();

      // frame from an unloaded buffer: length and markers only
      run_frame(0, 0, -1, nst);
      check("empty_count", got.size(), NOUT);

      load_ramp();
      run_frame(0, 0, -1, nst);
      check("ramp_count", got.size(), NOUT);
      check("ramp_first_lat", first_cyc - go_cyc, 2);
      check("ramp_done_lat", done_cyc - go_cyc, NOUT + 2);
      check("ramp_seq", ramp_mismatches(), 0);
      check("sol_count", nsol, OH);
      check("eol_count", neol, OH);
`ifdef FEEDER_PAD_EN
      check("pad_0_0", got[0], 0);
      check("pad_2_2", got[2 * OW + 2], 8'h00);
      check("pad_2_3", got[2 * OW + 3], 8'h01);
      check("pad_31_31", got[NOUT - 1], 0);
`else
      check("pix_27", got[27], 27);
      check("pix_300", got[300], 44);
      check("pix_783", got[783], 15);
`endif

      run_frame(1, 0, -1, nst);
      check("bp_count", got.size(), NOUT);
      check("bp_seq", ramp_mismatches(), 0);
      check("bp_done_lat", done_cyc - go_cyc, NOUT + 2 + nst);

      run_frame(3, 0, -1, nst);
      check("prot_seq", ramp_mismatches(), 0);
      repeat (10) tick();
      check("no_second_frame", busy, 0);
      wr_en   = 1;
      wr_addr = AW'(900);
      wr_data = 8'hAA;
      tick();
      wr_en = 0;
      run_frame(0, 0, -1, nst);
      check("oob_write_seq", ramp_mismatches(), 0);

      run_frame(0, 0, 400, nst);
      check("rst_at_400", got.size(), 400);
      tick();
      run_frame(2, 1, -1, nst);
      check("post_rst_count", got.size(), NOUT);
      check("post_rst_seq", ramp_mismatches(), 0);

      // random image (some addresses out of range), then a randomly stalled frame
      repeat (1200) begin
         wr_en   = $urandom_range(0, 1);
         wr_addr = AW'($urandom_range(0, 1023));
         wr_data = DW'($urandom);
         stall   = $urandom_range(0, 1);
         tick();
      end
      idle_inputs();
      tick();
      run_frame(2, 1, -1, nst);
      check("rand_count", got.size(), NOUT);
      check("rand_sol_count", nsol, OH);
      tick();
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
